neuron_seq_ctrl: RTL and testbench
==================================

# neuron_seq_ctrl

Sequencing controller for the single-neuron datapath (input selection, MAC, activation). On a `start` pulse it clears the MAC accumulator and input-selection index, then issues N multiply-accumulate steps, optionally stalled by `hold`. It then strobes the activation stage and reports completion with a one-cycle `done` pulse. It drives the datapath's `init`, `inc`, `ld_reg` and `ready` controls directly, and is the only block allowed to drive them.

## Interface
- `n`, default 2: number of input/weight element pairs per neuron evaluation. Must be ≥ 1. Matches the datapath's `n`.
- `CW`, default 4: index counter width. Must satisfy 2^CW > n.

- `clk`  in  1  rising-edge clock; the only clock.
- `rst`  in  1  reset, synchronous and active-high. Forces IDLE and all outputs to 0.
- `start`  in  1  request one neuron evaluation. Sampled only in IDLE and DONE.
- `hold`  in  1  stall; while high in ACC, no MAC step occurs and the index is frozen.
- `init`  out  1  clear MAC accumulator and input-selection index (datapath `init`).
- `inc`  out  1  advance input-selection index (datapath `inc`).
- `ld_reg`  out  1  load MAC accumulator with the new partial sum (datapath `ld_reg`).
- `ready`  out  1  activation output valid / capture strobe (datapath `ready`).
- `idx`  out  CW  index of the element pair being accumulated.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle completion pulse.

## Operation
- States: IDLE, INIT, ACC, ACT, DONE. Binary-encoded state register. All outputs are Moore-decoded from the registered state plus `hold` (the `hold` dependence applies to `inc`/`ld_reg` only).
- IDLE: all controls 0, `busy`=0. If `start`=1, go to INIT; otherwise stay.
- INIT: `init`=1 for exactly one cycle; `idx` cleared to 0. Go to ACC.
- ACC with `hold`=0: `inc`=`ld_reg`=1. `idx` increments at the clock edge. If `idx`==n-1, go to ACT and leave `idx` at n-1.
- ACC with `hold`=1: `inc`=`ld_reg`=0. `idx` and state unchanged. No limit on hold length.
- ACT: `ready`=1 for one cycle. Go to DONE.
- DONE: `done`=1 for one cycle. If `start`=1, go to INIT (back-to-back evaluation); else go to IDLE.
- `start` in INIT, ACC or ACT is ignored and not queued.
- `hold` outside ACC has no effect.
- `idx` keeps its last value in ACT, DONE and IDLE. It changes only in INIT (cleared to 0) and in non-held ACC (incremented).
- Invalid state encodings go to IDLE on the next clock.
- Counter arithmetic is unsigned, CW bits. `idx` never exceeds n-1, so it never wraps.

## Timing
- Reset: all outputs 0 (`init`, `inc`, `ld_reg`, `ready`, `busy`, `done`, `idx`) on the cycle after `rst` is sampled high.
- `rst` asserted mid-operation has priority over everything. The controller goes to IDLE on the next edge and no further `done` or `ready` is issued for the aborted evaluation.
- Start sampled high in IDLE at edge k, with no hold:
  - INIT during cycle k+1.
  - ACC during cycles k+2 .. k+n+1 (exactly n cycles with `inc`=`ld_reg`=1).
  - ACT at k+n+2.
  - DONE at k+n+3.
  - Latency from start to done is n+3 cycles. Each held cycle adds one.
- Back-to-back: `start` high during DONE puts INIT in the next cycle. Steady-state throughput is one evaluation per n+3 cycles.
- `init` and `ld_reg` are never high in the same cycle. `ready` is never high together with `inc`.
- n=1: ACC lasts exactly one unheld cycle; `idx` stays 0 throughout.

## Test plan
- Reset: assert `rst` 2 cycles with `start`=1 -> all outputs 0, state IDLE, `idx`=0. After release with `start` still 1 -> INIT on the following cycle.
- Basic run, n=2: `start` pulse at cycle 0 -> `init` at 1; `inc`/`ld_reg` at 2–3 with `idx` 0→1; `ready` at 4; `done` at 5; `busy` high for cycles 1–5.
- Hold, n=2: `hold`=1 at cycles 3–4 -> `inc`/`ld_reg` low at 3–4, `idx` frozen at 1, `ready` at 6, `done` at 7. A `start` pulse during ACC is ignored (only one `done`).
- Back-to-back, n=2: `start` held high continuously -> `done` at 5, `init` at 6, `done` at 10; period 5 cycles.
- Reset mid-ACC, n=4: `rst` at cycle 3 -> IDLE at 4, all outputs 0, no `ready`/`done` pulse afterward. A new `start` completes normally in n+3 = 7 cycles.
- n=1 build: `start` at 0 -> `init` 1, `inc`/`ld_reg` 2, `ready` 3, `done` 4, `idx`=0 throughout.

Source files
------------

// File: rtl/neuron_seq_ctrl.sv
// ---------------------------------------------------------------------------
// neuron_seq_ctrl
// Sequencing controller for the single-neuron datapath. A start request
// clears the MAC accumulator and input-selection index, runs n MAC steps
// (each can be stalled with hold), strobes the activation capture, and then
// gives a one-cycle done pulse. This block is the sole driver of the
// datapath controls init / inc / ld_reg / ready.
//
// Parameters
//   n   : element pairs per neuron evaluation (>= 1)
//   CW  : index counter width (2**CW > n)
//
// Ports
//   clk    : rising-edge clock
//   rst    : synchronous active-high reset (forces IDLE, outputs 0)
//   start  : evaluation request, sampled in IDLE and DONE only
//   hold   : stall of the MAC phase
//   init   : clear accumulator and index (datapath)
//   inc    : advance input-selection index (datapath)
//   ld_reg : load accumulator with new partial sum (datapath)
//   ready  : activation output valid / capture strobe (datapath)
//   idx    : index of the element pair being accumulated
//   busy   : high in every state except IDLE
//   done   : one-cycle completion pulse
// ---------------------------------------------------------------------------
module neuron_seq_ctrl #(
  parameter int n  = 2,
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          hold,
  output logic          init,
  output logic          inc,
  output logic          ld_reg,
  output logic          ready,
  output logic [CW-1:0] idx,
  output logic          busy,
  output logic          done
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    INIT = 3'd1,
    ACC  = 3'd2,
    ACT  = 3'd3,
    DONE = 3'd4
  } state_t;

  localparam logic [CW-1:0] LAST_IDX = CW'(n - 1);

  state_t state;
  state_t state_nxt;

  logic last_step;

  // The final MAC step is an unheld ACC cycle with the index at n-1.
  assign last_step = (idx == LAST_IDX);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = IDLE;
    case (state)
      IDLE:    state_nxt = start ? INIT : IDLE;
      INIT:    state_nxt = ACC;
      ACC: begin
        if (hold)           state_nxt = ACC;
        else if (last_step) state_nxt = ACT;
        else                state_nxt = ACC;
      end
      ACT:     state_nxt = DONE;
      DONE:    state_nxt = start ? INIT : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output decode (Moore; hold only gates the MAC step controls)
  always_comb begin
    init   = 1'b0;
    inc    = 1'b0;
    ld_reg = 1'b0;
    ready  = 1'b0;
    busy   = 1'b0;
    done   = 1'b0;
    case (state)
      IDLE: begin
      end
      INIT: begin
        init = 1'b1;
        busy = 1'b1;
      end
      ACC: begin
        inc    = ~hold;
        ld_reg = ~hold;
        busy   = 1'b1;
      end
      ACT: begin
        ready = 1'b1;
        busy  = 1'b1;
      end
      DONE: begin
        done = 1'b1;
        busy = 1'b1;
      end
      default: begin
      end
    endcase
  end

  // Index counter: cleared by INIT, advanced by every unheld ACC step except
  // the last, so it rests at n-1 and never wraps.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx <= '0;
    end else if (state == INIT) begin
      idx <= '0;
    end else if ((state == ACC) && !hold && !last_step) begin
      idx <= idx + 1'b1;
    end
  end

endmodule

// File: tb/tb_neuron_seq_ctrl.sv
module tb_neuron_seq_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b0;

  logic s2 = 1'b0, h2 = 1'b0;
  logic s1 = 1'b0, h1 = 1'b0;
  logic s4 = 1'b0, h4 = 1'b0;

  logic init2, inc2, ld2, rdy2, busy2, done2;
  logic init1, inc1, ld1, rdy1, busy1, done1;
  logic init4, inc4, ld4, rdy4, busy4, done4;
  logic [3:0] idx2, idx1, idx4;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  neuron_seq_ctrl #(.n(2), .CW(4)) dut2 (
    .clk(clk), .rst(rst), .start(s2), .hold(h2),
    .init(init2), .inc(inc2), .ld_reg(ld2), .ready(rdy2),
    .idx(idx2), .busy(busy2), .done(done2)
  );

  neuron_seq_ctrl #(.n(1), .CW(4)) dut1 (
    .clk(clk), .rst(rst), .start(s1), .hold(h1),
    .init(init1), .inc(inc1), .ld_reg(ld1), .ready(rdy1),
    .idx(idx1), .busy(busy1), .done(done1)
  );

  neuron_seq_ctrl #(.n(4), .CW(4)) dut4 (
    .clk(clk), .rst(rst), .start(s4), .hold(h4),
    .init(init4), .inc(inc4), .ld_reg(ld4), .ready(rdy4),
    .idx(idx4), .busy(busy4), .done(done4)
  );

  // Output vector order: {init, inc, ld_reg, ready, busy, done}
  task automatic test_reset();
    logic [17:0] got;
    logic [11:0] gidx;
    rst = 1'b1; s2 = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(posedge clk); #1;
      @(negedge clk);
      got  = {init2, inc2, ld2, rdy2, busy2, done2,
              init1, inc1, ld1, rdy1, busy1, done1,
              init4, inc4, ld4, rdy4, busy4, done4};
      gidx = {idx2, idx1, idx4};
      checks++;
      if (got !== 18'b0) begin
        errors++;
        $display("FAIL reset_outs c=%0d got=%b exp=%b", c, got, 18'b0);
      end
      checks++;
      if (gidx !== 12'h000) begin
        errors++;
        $display("FAIL reset_idx c=%0d got=%h exp=%h", c, gidx, 12'h000);
      end
    end
    // Release with start still high: IDLE now, INIT next cycle.
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (busy2 !== 1'b0) begin
      errors++;
      $display("FAIL reset_release_idle got busy=%b exp=%b", busy2, 1'b0);
    end
    @(posedge clk); #1;
    s2 = 1'b0;
    @(negedge clk);
    got[5:0] = {init2, inc2, ld2, rdy2, busy2, done2};
    checks++;
    if (got[5:0] !== 6'b100010) begin
      errors++;
      $display("FAIL reset_release_init got=%b exp=%b", got[5:0], 6'b100010);
    end
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
    end
    @(negedge clk);
    checks++;
    if (busy2 !== 1'b0) begin
      errors++;
      $display("FAIL reset_run_settle got busy=%b exp=%b", busy2, 1'b0);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    logic [5:0] got, exp;
    logic [3:0] eidx;
    for (int c = 0; c <= 8; c++) begin
      s2 = (c == 0);
      @(negedge clk);
      got = {init2, inc2, ld2, rdy2, busy2, done2};
      exp = {c == 1, c == 2 || c == 3, c == 2 || c == 3, c == 4,
             c >= 1 && c <= 5, c == 5};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL basic_outs c=%0d got=%b exp=%b", c, got, exp);
      end
      if (c >= 2) begin
        eidx = (c == 2) ? 4'd0 : 4'd1;
        checks++;
        if (idx2 !== eidx) begin
          errors++;
          $display("FAIL basic_idx c=%0d got=%0d exp=%0d", c, idx2, eidx);
        end
      end
      @(posedge clk); #1;
    end
    s2 = 1'b0;
  endtask

  task automatic test_hold();
    logic [5:0] got, exp;
    logic [3:0] eidx;
    for (int c = 0; c <= 11; c++) begin
      s2 = (c == 0) || (c == 3);
      h2 = (c == 0) || (c == 3) || (c == 4) || (c == 6);
      @(negedge clk);
      got = {init2, inc2, ld2, rdy2, busy2, done2};
      exp = {c == 1, c == 2 || c == 5, c == 2 || c == 5, c == 6,
             c >= 1 && c <= 7, c == 7};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL hold_outs c=%0d got=%b exp=%b", c, got, exp);
      end
      if (c >= 2) begin
        eidx = (c == 2) ? 4'd0 : 4'd1;
        checks++;
        if (idx2 !== eidx) begin
          errors++;
          $display("FAIL hold_idx c=%0d got=%0d exp=%0d", c, idx2, eidx);
        end
      end
      @(posedge clk); #1;
    end
    s2 = 1'b0; h2 = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [5:0] got, exp;
    logic [3:0] eidx;
    for (int c = 0; c <= 12; c++) begin
      s2 = (c <= 9);
      @(negedge clk);
      got = {init2, inc2, ld2, rdy2, busy2, done2};
      exp = {c == 1 || c == 6,
             c == 2 || c == 3 || c == 7 || c == 8,
             c == 2 || c == 3 || c == 7 || c == 8,
             c == 4 || c == 9,
             c >= 1 && c <= 10,
             c == 5 || c == 10};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL b2b_outs c=%0d got=%b exp=%b", c, got, exp);
      end
      if (c >= 2 && c != 6) begin
        eidx = (c == 2 || c == 7) ? 4'd0 : 4'd1;
        checks++;
        if (idx2 !== eidx) begin
          errors++;
          $display("FAIL b2b_idx c=%0d got=%0d exp=%0d", c, idx2, eidx);
        end
      end
      @(posedge clk); #1;
    end
    s2 = 1'b0;
  endtask

  task automatic test_rst_mid();
    logic [5:0] got, exp;
    logic [3:0] eidx;
    for (int c = 0; c <= 10; c++) begin
      s4  = (c == 0);
      rst = (c == 3);
      @(negedge clk);
      got = {init4, inc4, ld4, rdy4, busy4, done4};
      exp = {c == 1, c == 2 || c == 3, c == 2 || c == 3, 1'b0,
             c >= 1 && c <= 3, 1'b0};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL rstmid_outs c=%0d got=%b exp=%b", c, got, exp);
      end
      if (c >= 2) begin
        eidx = (c == 3) ? 4'd1 : 4'd0;
        checks++;
        if (idx4 !== eidx) begin
          errors++;
          $display("FAIL rstmid_idx c=%0d got=%0d exp=%0d", c, idx4, eidx);
        end
      end
      @(posedge clk); #1;
    end
    rst = 1'b0;
    // Fresh evaluation after the abort: n+3 = 7 cycles to done.
    for (int c = 0; c <= 9; c++) begin
      s4 = (c == 0);
      @(negedge clk);
      got = {init4, inc4, ld4, rdy4, busy4, done4};
      exp = {c == 1, c >= 2 && c <= 5, c >= 2 && c <= 5, c == 6,
             c >= 1 && c <= 7, c == 7};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL rstmid_rerun_outs c=%0d got=%b exp=%b", c, got, exp);
      end
      if (c >= 1) begin
        eidx = (c <= 2) ? 4'd0 : (c <= 5) ? 4'(c - 2) : 4'd3;
        checks++;
        if (idx4 !== eidx) begin
          errors++;
          $display("FAIL rstmid_rerun_idx c=%0d got=%0d exp=%0d", c, idx4, eidx);
        end
      end
      @(posedge clk); #1;
    end
    s4 = 1'b0;
  endtask

  task automatic test_n1();
    logic [5:0] got, exp;
    for (int c = 0; c <= 7; c++) begin
      s1 = (c == 0);
      h1 = (c == 1) || (c == 3);
      @(negedge clk);
      got = {init1, inc1, ld1, rdy1, busy1, done1};
      exp = {c == 1, c == 2, c == 2, c == 3, c >= 1 && c <= 4, c == 4};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL n1_outs c=%0d got=%b exp=%b", c, got, exp);
      end
      checks++;
      if (idx1 !== 4'd0) begin
        errors++;
        $display("FAIL n1_idx c=%0d got=%0d exp=%0d", c, idx1, 4'd0);
      end
      @(posedge clk); #1;
    end
    s1 = 1'b0; h1 = 1'b0;
  endtask

  initial begin
    @(posedge clk); #1;
    test_reset();
    test_basic();
    test_hold();
    test_back_to_back();
    test_rst_mid();
    test_n1();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
